// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pulls words from a synchronous FIFO with one-cycle read latency
// and presents them as a framed valid/ready stream through a 2-entry output buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  busy
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_state_t;

    occ_state_t state, state_nxt;

    logic                  in_flight;
    logic                  push;
    logic                  pop;
    logic [1:0]            occ;
    logic [2:0]            credit;
    logic [DATA_WIDTH-1:0] head, tail;
    logic [BEAT_W-1:0]     beat;

    assign push = in_flight;
    assign pop  = m_valid && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        m_valid = (state != EMPTY);
        busy    = (state != EMPTY) || in_flight;
        m_data  = head;
        m_last  = (state != EMPTY) && (beat == BEAT_LAST);
        case (state)
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
    end

    // Credit counts words already committed to the buffer; a pop this cycle frees a slot
    // in time for a read issued now, which is what sustains one word per cycle.
    always_comb begin
        credit     = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
        fifo_rd_en = rst_n && enable && !fifo_empty && (credit < 3'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            head      <= '0;
            tail      <= '0;
            beat      <= '0;
            pkt_count <= '0;
        end else begin
            in_flight <= fifo_rd_en && !fifo_empty;
            case (state)
                EMPTY: if (push) head <= fifo_dout;
                ONE: begin
                    if (push && pop)  head <= fifo_dout;
                    else if (push)    tail <= fifo_dout;
                end
                TWO:     if (pop) head <= tail;
                default: ;
            endcase
            if (pop) begin
                beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
                if (m_last) pkt_count <= pkt_count + 1'b1;
            end
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == TWO && push));

endmodule
